// File: rtl/bcd_to_bin_conv_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_conv_if -- request/result bundle for the BCD-to-binary converter.
//
// Handshake: the requester raises start with hundreds/tens/units valid. The
// converter samples them on any posedge where it is not busy, which includes
// the done cycle. While busy=1, start and the digits are ignored. done is a
// one-cycle pulse marking binary/err as fresh. Those outputs then hold until
// the next done pulse. There is no back-pressure on the result side.
//
// Signals:
//   start      requester -> converter  conversion request
//   hundreds   requester -> converter  BCD hundreds digit
//   tens       requester -> converter  BCD tens digit
//   units      requester -> converter  BCD units digit
//   busy       converter -> requester  conversion in progress
//   done       converter -> requester  one-cycle result-valid pulse
//   binary     converter -> requester  10-bit result of the last conversion
//   err        converter -> requester  invalid-digit flag of the last conversion
//   state_dbg  converter -> observer   FSM state (debug)
//   step_dbg   converter -> observer   CONV step index (debug)
// ---------------------------------------------------------------------------
interface bcd_to_bin_conv_if;
  logic       start;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] units;
  logic       busy;
  logic       done;
  logic [9:0] binary;
  logic       err;
  logic [1:0] state_dbg;
  logic [1:0] step_dbg;

  modport master (
    output start, hundreds, tens, units,
    input  busy, done, binary, err, state_dbg, step_dbg
  );

  modport slave (
    input  start, hundreds, tens, units,
    output busy, done, binary, err, state_dbg, step_dbg
  );
endinterface

// File: rtl/bcd_to_bin_conv.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_conv -- sequential three-digit BCD to 10-bit binary converter.
//
// Once start is accepted, the converter latches the digits. It then runs
// three multiply-by-ten-and-add steps (hundreds, tens, units) on an 11-bit
// accumulator. In the following cycle it pulses done, with binary/err updated.
// Throughput is one conversion per 4 cycles when start is re-issued in the
// done cycle.
//
// Ports:
//   clk   clock, all state changes on posedge
//   rst   asynchronous, active-high reset
//   bus   bcd_to_bin_conv_if.slave: start/hundreds/tens/units in,
//         busy/done/binary/err out, plus state_dbg/step_dbg debug outputs
//
// Configuration macro: BCD_DIGIT_CHECK_EN
//   defined   -> a latched digit > 9 completes with err=1, binary=0
//   undefined -> err is always 0; digits > 9 are used arithmetically and
//                binary = (h*100 + t*10 + u) mod 1024
// ---------------------------------------------------------------------------
module bcd_to_bin_conv (
  input logic                clk,
  input logic                rst,
  bcd_to_bin_conv_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [10:0] acc_q, acc_d;
  logic [3:0]  dig_h_q, dig_h_d;
  logic [3:0]  dig_t_q, dig_t_d;
  logic [3:0]  dig_u_q, dig_u_d;
  logic [9:0]  binary_q, binary_d;
  logic        err_q, err_d;

  // Working values for the current CONV step.
  logic [3:0]  cur_digit;
  logic [10:0] acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_q   <= 2'd0;
      acc_q    <= 11'd0;
      dig_h_q  <= 4'd0;
      dig_t_q  <= 4'd0;
      dig_u_q  <= 4'd0;
      binary_q <= 10'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      dig_h_q  <= dig_h_d;
      dig_t_q  <= dig_t_d;
      dig_u_q  <= dig_u_d;
      binary_q <= binary_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    acc_d     = acc_q;
    dig_h_d   = dig_h_q;
    dig_t_d   = dig_t_q;
    dig_u_d   = dig_u_q;
    binary_d  = binary_q;
    err_d     = err_q;
    cur_digit = 4'd0;
    acc_next  = 11'd0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          dig_h_d = bus.hundreds;
          dig_t_d = bus.tens;
          dig_u_d = bus.units;
          acc_d   = 11'd0;
          step_d  = 2'd0;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CONV: begin
        case (step_q)
          2'd0:    cur_digit = dig_h_q;
          2'd1:    cur_digit = dig_t_q;
          default: cur_digit = dig_u_q;
        endcase
        // The largest reachable value is 1665 (F/F/F), which fits in 11 bits.
        // Intermediate products are truncated to 11 bits and are never
        // wider than that for 4-bit digits.
        acc_next = acc_q * 11'd10 + {7'd0, cur_digit};
        acc_d    = acc_next;

        // Step 3 cannot be reached. Treating it as the last step keeps the
        // FSM from looping if the state is ever corrupted.
        if (step_q >= 2'd2) begin
          state_d = S_DONE;
`ifdef BCD_DIGIT_CHECK_EN
          if ((dig_h_q > 4'd9) || (dig_t_q > 4'd9) || (dig_u_q > 4'd9)) begin
            binary_d = 10'd0;
            err_d    = 1'b1;
          end else begin
            binary_d = acc_next[9:0];
            err_d    = 1'b0;
          end
`else
          binary_d = acc_next[9:0];
          err_d    = 1'b0;
`endif
        end else begin
          step_d = step_q + 2'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q == S_CONV);
  assign bus.done      = (state_q == S_DONE);
  assign bus.binary    = binary_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state_q;
  assign bus.step_dbg  = step_q;

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
module tb_bcd_to_bin_conv;

  logic clk;
  logic rst;

  bcd_to_bin_conv_if bus ();

  bcd_to_bin_conv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Expected {err, binary} per completed conversion.
  logic [10:0] exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [10:0] model(input int h, input int t, input int u);
    int v;
    v = h * 100 + t * 10 + u;
`ifdef BCD_DIGIT_CHECK_EN
    if (h > 9 || t > 9 || u > 9) return {1'b1, 10'd0};
`endif
    return {1'b0, 10'(v % 1024)};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [9:0] prev_bin;
  logic       prev_err;

  always @(negedge clk) begin
    if (rst) begin
      prev_bin = 10'd0;
      prev_err = 1'b0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("binary", int'(bus.binary), int'(e[9:0]));
        check("err", int'(bus.err), int'(e[10]));
      end
      prev_bin = bus.binary;
      prev_err = bus.err;
    end else begin
      check("hold", int'({bus.err, bus.binary}), int'({prev_err, prev_bin}));
    end
  end

  // ---------------- driver tasks ----------------
  // Call with the bench just after a posedge (#1). It raises start so that the
  // next posedge accepts it, then times busy/done. It returns in the done cycle.
  task automatic do_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    int lat;
    int busy_cycles;
    bus.start    = 1'b1;
    bus.hundreds = h;
    bus.tens     = t;
    bus.units    = u;
    exp_q.push_back(model(int'(h), int'(t), int'(u)));
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    busy_cycles = 0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.busy) busy_cycles++;
    end
    check("done_latency", lat, 3);
    check("busy_cycles", busy_cycles, 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_seen;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.hundreds = 4'd0;
    bus.tens     = 4'd0;
    bus.units    = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_binary", int'(bus.binary), 0);
    check("rst_err", int'(bus.err), 0);

    // Release reset away from the edge. The first posedge afterwards must
    // accept start.
    @(negedge clk); #1;
    rst = 1'b0;
    do_conv(4'd1, 4'd2, 4'd3);
    idle(2);

    // Back-to-back: the second start is raised in the done cycle.
    do_conv(4'd9, 4'd9, 4'd9);
    do_conv(4'd0, 4'd0, 4'd0);
    idle(1);

    // Start held high through CONV with other digits that toggle. Only one
    // conversion may complete.
    bus.start    = 1'b1;
    bus.hundreds = 4'd4;
    bus.tens     = 4'd5;
    bus.units    = 4'd6;
    exp_q.push_back(model(4, 5, 6));
    @(posedge clk); #1;
    bus.hundreds = 4'd7; bus.tens = 4'd7; bus.units = 4'd7;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.hundreds = 4'($urandom_range(0, 15));
      bus.tens     = 4'($urandom_range(0, 15));
      bus.units    = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    check("held_start_done", int'(bus.done), 1);
    bus.start = 1'b0;
    idle(6);

    // Invalid digits, then a valid conversion after them. The model covers
    // both macro settings.
    do_conv(4'd1, 4'hA, 4'd3);
    do_conv(4'd0, 4'd4, 4'd2);
    do_conv(4'hF, 4'hF, 4'hF);
    idle(1);
    do_conv(4'd5, 4'd5, 4'd5);

    // Reset during CONV step 1 of 3/2/1. No result is expected.
    idle(1);
    bus.start = 1'b1;
    bus.hundreds = 4'd3; bus.tens = 4'd2; bus.units = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    check("step1_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_binary", int'(bus.binary), 0);
    check("abort_err", int'(bus.err), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);
    do_conv(4'd0, 4'd0, 4'd7);
    idle(1);

    // Random conversions with random gaps. A gap of 0 gives back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] h, t, u;
      if ($urandom_range(0, 3) == 0) begin
        h = 4'($urandom_range(0, 15));
        t = 4'($urandom_range(0, 15));
        u = 4'($urandom_range(0, 15));
      end else begin
        h = 4'($urandom_range(0, 9));
        t = 4'($urandom_range(0, 9));
        u = 4'($urandom_range(0, 9));
      end
      do_conv(h, t, u);
      idle(int'($urandom_range(0, 2)));
    end

    idle(6);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Time limit in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_to_bin_conv.md
BCD_TO_BIN_CONV -- requirements
Module: bcd_to_bin_conv

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on posedge clk.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: start  input  1  conversion request, sampled on posedge clk.
REQ-004 SHALL: hundreds  input  4  BCD hundreds digit, sampled with start.
REQ-005 SHALL: tens  input  4  BCD tens digit, sampled with start.
REQ-006 SHALL: units  input  4  BCD units digit, sampled with start.
REQ-007 SHALL: busy  output  1  high while a conversion is in progress.
REQ-008 SHALL: done  output  1  one-cycle pulse; result and err valid.
REQ-009 SHALL: binary  output  10  binary result of the last completed conversion.
REQ-010 SHALL: err  output  1  invalid-digit flag of the last completed conversion.

Function
REQ-011 SHALL: FSM states IDLE, CONV, DONE; CONV carries a 2-bit step index 0..2.
REQ-012 SHALL: IDLE or DONE with start=1 at an edge -> latch all three digits, clear accumulator, enter CONV step 0.
REQ-013 SHALL: each CONV edge computes acc <= acc*10 + digit[step], with digit order hundreds, tens, units; accumulator is 11 bits.
REQ-014 SHALL: after CONV step 2 -> DONE; done=1 for exactly that cycle, binary <= acc[9:0], busy=0.
REQ-015 SHALL: DONE with start=0 -> IDLE.
REQ-016 SHALL: latency: start accepted at edge k -> done high in the cycle after edge k+3; busy high in the cycles after edges k..k+2.
REQ-017 SHALL: start while busy is ignored; latched digits are not disturbed by input changes during CONV.
REQ-018 SHALL: start in the DONE cycle is accepted (back-to-back conversions, 4-cycle throughput).
REQ-019 SHALL: binary and err hold their values until the next done; they are never updated mid-conversion.
REQ-020 SHALL: valid inputs 000..999 yield an exact result, 0..999, with no truncation.

Reset
REQ-021 SHALL: rst=1 forces state IDLE, busy=0, done=0, err=0, binary=0, accumulator=0, latched digits=0, immediately and regardless of clk.
REQ-022 SHALL: rst during CONV abandons the conversion; no done pulse follows deassertion until a new start.
REQ-023 SHALL: first accepted start is at the first posedge after rst deasserts.

Configuration
REQ-024 SHALL: macro BCD_DIGIT_CHECK_EN defined -> any latched digit >9 makes the completing done assert err=1 and binary=0; otherwise err=0.
REQ-025 SHALL: macro undefined -> err tied 0; digits >9 are used arithmetically as-is, and binary = (h*100+t*10+u) mod 1024.

Verification
REQ-026 SHALL: start with h/t/u=1/2/3 -> done 4 cycles later, binary=123, err=0, busy high for exactly 3 cycles.
REQ-027 SHALL: 9/9/9 then 0/0/0 back-to-back (start in DONE cycle) -> binary=999, then 0 four cycles later.
REQ-028 SHALL: start 4/5/6, then start=1 with 7/7/7 held and digits toggled during CONV -> one done only, binary=456.
REQ-029 SHALL: with BCD_DIGIT_CHECK_EN, 1/A/3 -> err=1, binary=0; following 0/4/2 -> err=0, binary=42.
REQ-030 SHALL: without the macro, F/F/F -> binary=641 (1665 mod 1024), err=0.
REQ-031 SHALL: rst pulse at CONV step 1 of 3/2/1 -> all outputs 0 at once; no done until a new start; next 0/0/7 -> binary=7.
